inst_fetch: RTL and testbench

- Fetch front end that sits directly upstream of the synchronous instruction memory.
- Generates the fetch PC and the memory chip-enable, and captures the memory read data returned one cycle later.
- Tags each returned word with its PC and buffers the pairs in a small FIFO, so that downstream stalls never drop instructions.
- Handles branch redirects by squashing wrong-path requests and flushing the buffer.

---
 rtl/inst_fetch.sv | 117 +++++++++++
 tb/tb_inst_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC generation, memory request,
// PC tagging of returned words and a small decoupling buffer.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        inst_ce_o,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_rdata_i,
  output logic        inst_branch_flag_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   pc_inflight_q, pc_inflight_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];

  logic          pop;
  logic          push;
  logic [CW:0]   pending;
  logic          unused_tgt;

  assign unused_tgt = ^branch_target_i[1:0];

  assign inst_addr_o        = pc_q;
  assign inst_branch_flag_o = branch_flag_i;
  assign valid_o            = (occ_q != '0);
  assign pc_o   = valid_o ? buf_pc_q[rd_ptr_q]   : 32'h0;
  assign inst_o = valid_o ? buf_inst_q[rd_ptr_q] : 32'h0;

  // Handshake decode: a branch squashes pop, capture and issue.
  always_comb begin
    pop     = valid_o & ~stall_i & ~branch_flag_i;
    push    = inflight_q & ~branch_flag_i;
    pending = {1'b0, occ_q}
            + {{CW{1'b0}}, inflight_q}
            - {{CW{1'b0}}, pop};
    inst_ce_o = ~reset & ~branch_flag_i
              & (pending < (CW+1)'(DEPTH));
  end

  // Next-state: redirect, or issue/capture/pop bookkeeping.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    pc_inflight_d = pc_q;
    occ_d         = occ_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (branch_flag_i) begin
      pc_d       = {branch_target_i[31:2], 2'b00};
      inflight_d = 1'b0;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      inflight_d = inst_ce_o;
      if (inst_ce_o) pc_d = pc_q + 32'd4;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      occ_d = occ_q
            + {{PW{1'b0}}, push}
            - {{PW{1'b0}}, pop};
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      pc_inflight_q <= 32'h0;
      occ_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      pc_inflight_q <= pc_inflight_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are qualified by occ, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= pc_inflight_q;
      buf_inst_q[wr_ptr_q] <= inst_rdata_i;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (
    @(posedge clock) disable iff (reset)
    !(push && !pop && occ_q == CW'(DEPTH))
  );
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed table, reset pulse and
// randomized traffic against a queue-level reference model.
module tb_inst_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        inst_ce_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_rdata_i;
  logic        inst_branch_flag_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int vectors = 0;
  int errors  = 0;

  inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .branch_flag_i      (branch_flag_i),
    .branch_target_i    (branch_target_i),
    .stall_i            (stall_i),
    .inst_ce_o          (inst_ce_o),
    .inst_addr_o        (inst_addr_o),
    .inst_rdata_i       (inst_rdata_i),
    .inst_branch_flag_o (inst_branch_flag_o),
    .valid_o            (valid_o),
    .pc_o               (pc_o),
    .inst_o             (inst_o)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a1234;
  endfunction

  // Synchronous instruction memory with flush-to-zero.
  always @(posedge clock or posedge reset) begin
    if (reset) inst_rdata_i <= 32'h0;
    else if (inst_branch_flag_o) inst_rdata_i <= 32'h0;
    else if (inst_ce_o) inst_rdata_i <= memf(inst_addr_o);
    else inst_rdata_i <= 32'hdeadbeef;
  end

  // Reference model: buffered PCs, one outstanding request, fetch PC.
  logic [31:0] mq[$];
  bit          mif_v;
  logic [31:0] mif_pc;
  logic [31:0] mfpc;

  task automatic model_reset();
    mq.delete();
    mif_v = 0;
    mif_pc = 0;
    mfpc = RPC;
  endtask

  typedef struct {
    bit          br;
    logic [31:0] tgt;
    bit          st;
    bit          ce;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[20];

  task automatic step(input bit br, input logic [31:0] tgt,
                      input bit st, input bit use_t,
                      input vec_t t, input string nm);
    bit ev, pop, ece;
    logic [31:0] epc, einst, eaddr;
    branch_flag_i = br;
    branch_target_i = tgt;
    stall_i = st;
    @(negedge clock);
    ev = (mq.size() != 0);
    epc = ev ? mq[0] : 32'h0;
    einst = ev ? memf(mq[0]) : 32'h0;
    pop = ev && !st && !br;
    ece = !br &&
      (int'(mq.size()) + int'(mif_v) - int'(pop) < DEPTH);
    eaddr = mfpc;
    vectors++;
    if (inst_ce_o !== ece || inst_addr_o !== eaddr ||
        valid_o !== ev || pc_o !== epc || inst_o !== einst ||
        inst_branch_flag_o !== br) begin
      errors++;
      $display("FAIL %s model: got ce=%b addr=%h v=%b pc=%h inst=%h bf=%b want ce=%b addr=%h v=%b pc=%h inst=%h bf=%b",
        nm, inst_ce_o, inst_addr_o, valid_o, pc_o, inst_o,
        inst_branch_flag_o, ece, eaddr, ev, epc, einst, br);
    end
    if (use_t) begin
      vectors++;
      if (inst_ce_o !== t.ce || inst_addr_o !== t.addr ||
          valid_o !== t.v || pc_o !== t.pc ||
          inst_o !== (t.v ? memf(t.pc) : 32'h0)) begin
        errors++;
        $display("FAIL %s table: got ce=%b addr=%h v=%b pc=%h want ce=%b addr=%h v=%b pc=%h",
          nm, inst_ce_o, inst_addr_o, valid_o, pc_o,
          t.ce, t.addr, t.v, t.pc);
      end
    end
    @(posedge clock);
    #1;
    if (br) begin
      mq.delete();
      mif_v = 0;
      mfpc = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (mif_v) mq.push_back(mif_pc);
      mif_v = ece;
      mif_pc = mfpc;
      if (ece) mfpc = mfpc + 32'd4;
    end
    if (mq.size() > DEPTH) begin
      vectors++;
      errors++;
      $display("FAIL %s model occupancy %0d exceeds %0d",
               nm, mq.size(), DEPTH);
    end
  endtask

  task automatic check_reset_outs(input string nm);
    vectors++;
    if (inst_ce_o !== 1'b0 || valid_o !== 1'b0 ||
        pc_o !== 32'h0 || inst_o !== 32'h0 ||
        inst_addr_o !== RPC) begin
      errors++;
      $display("FAIL %s: got ce=%b v=%b pc=%h inst=%h addr=%h want ce=0 v=0 pc=0 inst=0 addr=%h",
        nm, inst_ce_o, valid_o, pc_o, inst_o, inst_addr_o, RPC);
    end
  endtask

  initial begin
    vec_t z;
    z = '{0, 32'h0, 0, 0, 32'h0, 0, 32'h0};
    tbl[0]  = '{0, 0, 0, 1, RPC + 32'h00, 0, 32'h0};
    tbl[1]  = '{0, 0, 0, 1, RPC + 32'h04, 0, 32'h0};
    tbl[2]  = '{0, 0, 0, 1, RPC + 32'h08, 1, RPC + 32'h00};
    tbl[3]  = '{0, 0, 0, 1, RPC + 32'h0c, 1, RPC + 32'h04};
    tbl[4]  = '{0, 0, 1, 0, RPC + 32'h10, 1, RPC + 32'h08};
    tbl[5]  = '{0, 0, 1, 0, RPC + 32'h10, 1, RPC + 32'h08};
    tbl[6]  = '{0, 0, 0, 1, RPC + 32'h10, 1, RPC + 32'h08};
    tbl[7]  = '{0, 0, 0, 1, RPC + 32'h14, 1, RPC + 32'h0c};
    tbl[8]  = '{1, 32'h1c000103, 0, 0, RPC + 32'h18, 1,
                RPC + 32'h10};
    tbl[9]  = '{0, 0, 0, 1, 32'h1c000100, 0, 32'h0};
    tbl[10] = '{0, 0, 0, 1, 32'h1c000104, 0, 32'h0};
    tbl[11] = '{0, 0, 0, 1, 32'h1c000108, 1, 32'h1c000100};
    tbl[12] = '{1, 32'hfffffffc, 0, 0, 32'h1c00010c, 1,
                32'h1c000104};
    tbl[13] = '{0, 0, 0, 1, 32'hfffffffc, 0, 32'h0};
    tbl[14] = '{0, 0, 0, 1, 32'h00000000, 0, 32'h0};
    tbl[15] = '{0, 0, 0, 1, 32'h00000004, 1, 32'hfffffffc};
    tbl[16] = '{1, 32'h1c000200, 1, 0, 32'h00000008, 1,
                32'h00000000};
    tbl[17] = '{0, 0, 0, 1, 32'h1c000200, 0, 32'h0};
    tbl[18] = '{0, 0, 0, 1, 32'h1c000204, 0, 32'h0};
    tbl[19] = '{0, 0, 0, 1, 32'h1c000208, 1, 32'h1c000200};

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outs("reset_hold");
    reset = 1'b0;

    for (int i = 0; i < 20; i++)
      step(tbl[i].br, tbl[i].tgt, tbl[i].st, 1'b1, tbl[i],
           $sformatf("tbl%0d", i));

    // Long stall in steady flow, then release.
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 0, z, $sformatf("stall%0d", i));
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, z, $sformatf("unstall%0d", i));

    // Asynchronous reset pulse between edges.
    reset = 1'b1;
    #2;
    check_reset_outs("mid_reset");
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, z, $sformatf("restart%0d", i));

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit br, st;
      logic [31:0] tg;
      br = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 2) == 0);
      tg = $urandom();
      if ($urandom_range(0, 3) == 0)
        tg = 32'hfffffff0 | (tg & 32'hf);
      step(br, tg, st, 0, z, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
